// File: rtl/booth_r8_mult_pipe.sv
// booth_r8_mult_pipe
//   Three-stage radix-8 modified-Booth multiplier with a valid/ready stream
//   interface, per-operation signed/unsigned mode and a pass-through tag.
//     S1: Booth recode of in_y, 3X precompute, register operands and tag.
//     S2: partial-product select/negate, carry-save reduction to sum/carry.
//     S3: carry-propagate add, registered product.
//   A single global stall (advance) freezes every stage, bubbles included.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active high
//   in_valid   in   1      operand pair present
//   in_ready   out  1      block accepts this cycle (combinational from out_ready)
//   in_signed  in   1      1 = two's complement operands, 0 = unsigned
//   in_x       in   W      multiplicand
//   in_y       in   W      multiplier (Booth recoded)
//   in_tag     in   TAG_W  opaque tag
//   out_valid  out  1      product present
//   out_ready  in   1      consumer accepts
//   out_z      out  2W     product, registered
//   out_tag    out  TAG_W  tag of the same operation, registered
module booth_r8_mult_pipe #(
  parameter int W     = 24,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_z,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N  = (W + 3) / 3;  // ceil((W+1)/3) Booth digits
  localparam int YB = 3 * N + 1;    // recoding window incl. the y[-1] = 0 bit
  localparam int XW = W + 4;        // wide enough for +/-4X of a (W+2)-bit X
  localparam int ZW = 2 * W;

  // Digit window {y[3i+2], y[3i+1], y[3i], y[3i-1]} -> one-hot |d|
  // (bit0 = 1X, bit1 = 2X, bit2 = 3X, bit3 = 4X). The sign is the top bit.
  function automatic logic [3:0] booth_mag(input logic [3:0] win);
    case (win)
      4'b0001, 4'b0010, 4'b1101, 4'b1110: booth_mag = 4'b0001;
      4'b0011, 4'b0100, 4'b1011, 4'b1100: booth_mag = 4'b0010;
      4'b0101, 4'b0110, 4'b1001, 4'b1010: booth_mag = 4'b0100;
      4'b0111, 4'b1000:                   booth_mag = 4'b1000;
      default:                            booth_mag = 4'b0000;
    endcase
  endfunction

  logic advance;

  // S1 registers
  logic                  v1_q;
  logic                  sgn1_q;
  logic [W-1:0]          x1_q;
  logic [XW-1:0]         x3_1_q;
  logic [N-1:0]          neg1_q;
  logic [N-1:0][3:0]     mag1_q;
  logic [TAG_W-1:0]      tag1_q;

  // S2 registers
  logic                  v2_q;
  logic [ZW-1:0]         sum2_q;
  logic [ZW-1:0]         car2_q;
  logic [TAG_W-1:0]      tag2_q;

  // S3 registers
  logic                  v3_q;
  logic [ZW-1:0]         z3_q;
  logic [TAG_W-1:0]      tag3_q;

  assign advance   = !v3_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign out_z     = z3_q;
  assign out_tag   = tag3_q;

  // ---------------- S1 next state ----------------
  logic [W+1:0]      xe_in;
  logic [XW-1:0]     x3_d;
  logic [YB-1:0]     yb_d;
  logic [N-1:0]      neg_d;
  logic [N-1:0][3:0] mag_d;

  assign xe_in = {{2{in_signed & in_x[W-1]}}, in_x};
  assign x3_d  = {{2{xe_in[W+1]}}, xe_in} + {xe_in[W+1], xe_in, 1'b0};
  // Extension beyond W+2 bits only replicates the sign so the top window
  // stays well formed when 3N exceeds W+1.
  assign yb_d  = {{(3*N-W){in_signed & in_y[W-1]}}, in_y, 1'b0};

  genvar g;
  for (g = 0; g < N; g++) begin : g_recode
    assign neg_d[g] = yb_d[3*g+3];
    assign mag_d[g] = booth_mag(yb_d[3*g +: 4]);
  end

  // ---------------- S2 next state ----------------
  logic [W+1:0]  xe2;
  logic [XW-1:0] xm1;
  logic [XW-1:0] xm2;
  logic [XW-1:0] xm4;
  logic [ZW-1:0] ps [N+1];
  logic [ZW-1:0] pc [N+1];
  logic [ZW-1:0] corr;
  logic [ZW-1:0] sum_d;
  logic [ZW-1:0] car_d;

  assign xe2 = {{2{sgn1_q & x1_q[W-1]}}, x1_q};
  assign xm1 = {{2{xe2[W+1]}}, xe2};
  assign xm2 = {xe2[W+1], xe2, 1'b0};
  assign xm4 = {xe2, 2'b00};

  assign ps[0] = '0;
  assign pc[0] = '0;
  assign corr[ZW-1:3*N] = '0;

  for (g = 0; g < N; g++) begin : g_pp
    logic [XW-1:0] sel;
    logic [ZW-1:0] pp_inv;
    logic [ZW-1:0] pp;

    assign sel = ({XW{mag1_q[g][0]}} & xm1)    |
                 ({XW{mag1_q[g][1]}} & xm2)    |
                 ({XW{mag1_q[g][2]}} & x3_1_q) |
                 ({XW{mag1_q[g][3]}} & xm4);
    // Negation as one's complement here; the +1 rides in corr at bit 3g.
    assign pp_inv = {{(ZW-XW){sel[XW-1]}}, sel} ^ {ZW{neg1_q[g]}};
    assign pp     = pp_inv << (3*g);
    assign corr[3*g +: 3] = {2'b00, neg1_q[g]};

    assign ps[g+1] = ps[g] ^ pc[g] ^ pp;
    assign pc[g+1] = ((ps[g] & pc[g]) | (ps[g] & pp) | (pc[g] & pp)) << 1;
  end

  assign sum_d = ps[N] ^ pc[N] ^ corr;
  assign car_d = ((ps[N] & pc[N]) | (ps[N] & corr) | (pc[N] & corr)) << 1;

  // ---------------- S3 next state ----------------
  logic [ZW-1:0] z_d;
  assign z_d = sum2_q + car2_q;

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      sgn1_q <= 1'b0;
      x1_q   <= '0;
      x3_1_q <= '0;
      neg1_q <= '0;
      mag1_q <= '0;
      tag1_q <= '0;
      v2_q   <= 1'b0;
      sum2_q <= '0;
      car2_q <= '0;
      tag2_q <= '0;
      v3_q   <= 1'b0;
      z3_q   <= '0;
      tag3_q <= '0;
    end else if (advance) begin
      v1_q   <= in_valid;
      sgn1_q <= in_signed;
      x1_q   <= in_x;
      x3_1_q <= x3_d;
      neg1_q <= neg_d;
      mag1_q <= mag_d;
      tag1_q <= in_tag;
      v2_q   <= v1_q;
      sum2_q <= sum_d;
      car2_q <= car_d;
      tag2_q <= tag1_q;
      v3_q   <= v2_q;
      z3_q   <= z_d;
      tag3_q <= tag2_q;
    end
  end

endmodule

// File: tb/tb_booth_r8_mult_pipe.sv
module tb_booth_r8_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // W = 24 instance
  logic        a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready;
  logic [23:0] a_in_x, a_in_y;
  logic [3:0]  a_in_tag, a_out_tag;
  logic [47:0] a_out_z;

  // W = 8 instance
  logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
  logic [7:0]  b_in_x, b_in_y;
  logic [3:0]  b_in_tag, b_out_tag;
  logic [15:0] b_out_z;

  // W = 64 instance
  logic         c_in_valid, c_in_ready, c_in_signed, c_out_valid, c_out_ready;
  logic [63:0]  c_in_x, c_in_y;
  logic [3:0]   c_in_tag, c_out_tag;
  logic [127:0] c_out_z;

  int checks = 0;
  int errors = 0;

  booth_r8_mult_pipe #(.W(24), .TAG_W(4)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_signed(a_in_signed),
    .in_x(a_in_x), .in_y(a_in_y), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_z(a_out_z), .out_tag(a_out_tag)
  );

  booth_r8_mult_pipe #(.W(8), .TAG_W(4)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_signed(b_in_signed),
    .in_x(b_in_x), .in_y(b_in_y), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_z(b_out_z), .out_tag(b_out_tag)
  );

  booth_r8_mult_pipe #(.W(64), .TAG_W(4)) u_c (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_signed(c_in_signed),
    .in_x(c_in_x), .in_y(c_in_y), .in_tag(c_in_tag),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_z(c_out_z), .out_tag(c_out_tag)
  );

  // Exact product of two w-bit operands, truncated to 2w bits.
  function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                           input logic s, input int w);
    logic signed [129:0] a, b, p;
    logic [127:0] r;
    a = '0; b = '0; r = '0;
    for (int i = 0; i < 130; i++) begin
      if (i < w) begin
        a[i] = x[i];
        b[i] = y[i];
      end else begin
        a[i] = s & x[w-1];
        b[i] = s & y[w-1];
      end
    end
    p = a * b;
    for (int i = 0; i < 128; i++)
      if (i < 2 * w) r[i] = p[i];
    return r;
  endfunction

  function automatic logic [7:0] ycor(input logic [3:0] k);
    case (k)
      4'd0:  ycor = 8'h00; 4'd1:  ycor = 8'h01; 4'd2:  ycor = 8'h02; 4'd3:  ycor = 8'h03;
      4'd4:  ycor = 8'h07; 4'd5:  ycor = 8'h08; 4'd6:  ycor = 8'h55; 4'd7:  ycor = 8'h7F;
      4'd8:  ycor = 8'h80; 4'd9:  ycor = 8'h81; 4'd10: ycor = 8'hAA; 4'd11: ycor = 8'hFE;
      4'd12: ycor = 8'hFF; 4'd13: ycor = 8'h40; 4'd14: ycor = 8'h0F; default: ycor = 8'hF0;
    endcase
  endfunction

  // W = 8 operand sequence: all signed pairs, then every x against a corner set unsigned.
  function automatic logic [16:0] op8(input int n);
    logic [31:0] u;
    u = n;
    if (n < 65536) return {1'b1, u[15:8], u[7:0]};
    u = n - 65536;
    return {1'b0, u[11:4], ycor(u[3:0])};
  endfunction

  task automatic idle_all;
    a_in_valid = 0; a_in_signed = 0; a_in_x = '0; a_in_y = '0; a_in_tag = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_signed = 0; b_in_x = '0; b_in_y = '0; b_in_tag = '0; b_out_ready = 1;
    c_in_valid = 0; c_in_signed = 0; c_in_x = '0; c_in_y = '0; c_in_tag = '0; c_out_ready = 1;
  endtask

  task automatic test_reset;
    rst = 1;
    idle_all();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b required=0", a_out_valid); end
    checks++; if (a_out_z !== 48'h0) begin errors++; $display("FAIL reset_z actual=%h required=0", a_out_z); end
    checks++; if (a_out_tag !== 4'h0) begin errors++; $display("FAIL reset_tag actual=%h required=0", a_out_tag); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready actual=%b required=1", a_in_ready); end
    checks++; if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_w8_w64 actual=%b%b required=00", b_out_valid, c_out_valid); end
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready actual=%b required=1", a_in_ready); end
  endtask

  task automatic test_directed;
    logic [23:0] vx, vy;
    logic        vs;
    logic [47:0] vz;
    for (int v = 0; v < 4; v++) begin
      case (v)
        0:       begin vs = 0; vx = 24'hFFFFFF; vy = 24'hFFFFFF; vz = 48'hFFFFFE000001; end
        1:       begin vs = 1; vx = 24'h800000; vy = 24'h800000; vz = 48'h400000000000; end
        2:       begin vs = 1; vx = 24'h800000; vy = 24'h000001; vz = 48'hFFFFFF800000; end
        default: begin vs = 1; vx = 24'hFFFFFF; vy = 24'hFFFFFF; vz = 48'h000000000001; end
      endcase
      @(negedge clk);
      a_in_valid = 1; a_in_signed = vs; a_in_x = vx; a_in_y = vy; a_in_tag = 4'(v + 5);
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        a_in_valid = 0;
        #1;
        if (c < 3) begin
          checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL dir_early_valid vec=%0d cyc=%0d actual=%b required=0", v, c, a_out_valid); end
        end else begin
          checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL dir_valid vec=%0d actual=%b required=1", v, a_out_valid); end
          checks++; if (a_out_z !== vz) begin errors++; $display("FAIL dir_z vec=%0d actual=%h required=%h", v, a_out_z, vz); end
          checks++; if (a_out_tag !== 4'(v + 5)) begin errors++; $display("FAIL dir_tag vec=%0d actual=%h required=%h", v, a_out_tag, 4'(v + 5)); end
        end
      end
    end
  endtask

  task automatic test_stream;
    logic [23:0]  sx [100];
    logic [23:0]  sy [100];
    logic         ss [100];
    logic [31:0]  r;
    logic [127:0] e;
    for (int i = 0; i < 100; i++) begin
      r = $urandom; sx[i] = r[23:0];
      r = $urandom; sy[i] = r[23:0]; ss[i] = r[31];
    end
    sx[10] = 24'h800000; sy[10] = 24'h7FFFFF; ss[10] = 1;
    sx[11] = 24'h000000; sy[11] = 24'hFFFFFF; ss[11] = 0;
    sx[12] = 24'h7FFFFF; sy[12] = 24'h7FFFFF; ss[12] = 1;
    a_out_ready = 1;
    for (int c = 0; c < 103; c++) begin
      @(negedge clk);
      if (c < 100) begin
        a_in_valid = 1; a_in_signed = ss[c]; a_in_x = sx[c]; a_in_y = sy[c]; a_in_tag = 4'(c);
      end else a_in_valid = 0;
      #1;
      if (c >= 3) begin
        e = ref_mul({40'd0, sx[c-3]}, {40'd0, sy[c-3]}, ss[c-3], 24);
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid op=%0d actual=%b required=1", c - 3, a_out_valid); end
        checks++; if (a_out_z !== e[47:0]) begin errors++; $display("FAIL stream_z op=%0d actual=%h required=%h", c - 3, a_out_z, e[47:0]); end
        checks++; if (a_out_tag !== 4'(c - 3)) begin errors++; $display("FAIL stream_tag op=%0d actual=%h required=%h", c - 3, a_out_tag, 4'(c - 3)); end
      end
    end
    a_in_valid = 0;
  endtask

  task automatic test_back_to_back;
    logic [23:0]  px [20];
    logic [23:0]  py [20];
    logic         pm [20];
    logic [31:0]  r;
    logic [127:0] e;
    logic [47:0]  held_z;
    logic [3:0]   held_t;
    int nsent, nrecv;
    for (int i = 0; i < 20; i++) begin
      r = $urandom; px[i] = r[23:0];
      r = $urandom; py[i] = r[23:0]; pm[i] = r[30];
    end
    nsent = 0; nrecv = 0; held_z = '0; held_t = '0;
    for (int c = 0; c < 80 && nrecv < 20; c++) begin
      @(negedge clk);
      a_out_ready = !(c >= 6 && c < 11);
      if (nsent < 20) begin
        a_in_valid = 1; a_in_signed = pm[nsent]; a_in_x = px[nsent]; a_in_y = py[nsent];
        a_in_tag = 4'(nsent + 3);
      end else a_in_valid = 0;
      #1;
      if (c >= 6 && c < 11) begin
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d actual=%b required=0", c, a_in_ready); end
        if (c == 6) begin
          checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid actual=%b required=1", a_out_valid); end
          held_z = a_out_z; held_t = a_out_tag;
        end else begin
          checks++;
          if (a_out_z !== held_z || a_out_tag !== held_t) begin
            errors++; $display("FAIL stall_stable cyc=%0d actual=%h/%h required=%h/%h", c, a_out_z, a_out_tag, held_z, held_t);
          end
        end
      end
      if (a_out_valid === 1'b1 && a_out_ready) begin
        e = ref_mul({40'd0, px[nrecv]}, {40'd0, py[nrecv]}, pm[nrecv], 24);
        checks++; if (a_out_z !== e[47:0]) begin errors++; $display("FAIL bp_z op=%0d actual=%h required=%h", nrecv, a_out_z, e[47:0]); end
        checks++; if (a_out_tag !== 4'(nrecv + 3)) begin errors++; $display("FAIL bp_tag op=%0d actual=%h required=%h", nrecv, a_out_tag, 4'(nrecv + 3)); end
        nrecv++;
      end
      if (a_in_valid && a_in_ready === 1'b1) nsent++;
    end
    checks++; if (nrecv != 20) begin errors++; $display("FAIL bp_count actual=%0d required=20", nrecv); end
    a_in_valid = 0; a_out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate cyc=%0d actual=%b required=0", c, a_out_valid); end
    end
  endtask

  task automatic test_reset_mid;
    a_out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_in_valid = 1; a_in_signed = 0; a_in_x = 24'(c + 5); a_in_y = 24'h000007; a_in_tag = 4'(c + 10);
    end
    @(negedge clk);
    a_in_valid = 0;
    #1;
    checks++; if (a_out_valid !== 1'b1 || a_out_z !== 48'd35) begin errors++; $display("FAIL rstmid_inflight actual=%b/%h required=1/23", a_out_valid, a_out_z); end
    #1 rst = 1;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid actual=%b required=0", a_out_valid); end
    checks++; if (a_out_z !== 48'h0 || a_out_tag !== 4'h0) begin errors++; $display("FAIL rstmid_clear actual=%h/%h required=0/0", a_out_z, a_out_tag); end
    repeat (2) @(negedge clk);
    rst = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale cyc=%0d actual=%b required=0", c, a_out_valid); end
    end
    @(negedge clk);
    a_in_valid = 1; a_in_signed = 0; a_in_x = 24'h000010; a_in_y = 24'h000003; a_in_tag = 4'h9;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      a_in_valid = 0;
      #1;
      if (c < 3) begin
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early cyc=%0d actual=%b required=0", c, a_out_valid); end
      end else begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_z !== 48'h30 || a_out_tag !== 4'h9) begin
          errors++; $display("FAIL rstmid_first actual=%b/%h/%h required=1/30/9", a_out_valid, a_out_z, a_out_tag);
        end
      end
    end
  endtask

  task automatic test_w8;
    localparam int M = 65536 + 4096;
    logic [16:0]  op;
    logic [127:0] e;
    b_out_ready = 1;
    for (int c = 0; c < M + 3; c++) begin
      @(negedge clk);
      if (c < M) begin
        op = op8(c);
        b_in_valid = 1; b_in_signed = op[16]; b_in_x = op[15:8]; b_in_y = op[7:0]; b_in_tag = 4'(c);
      end else b_in_valid = 0;
      #1;
      if (c >= 3) begin
        op = op8(c - 3);
        e = ref_mul({56'd0, op[15:8]}, {56'd0, op[7:0]}, op[16], 8);
        checks++;
        if (b_out_valid !== 1'b1 || b_out_z !== e[15:0] || b_out_tag !== 4'(c - 3)) begin
          errors++;
          $display("FAIL w8 s=%b x=%h y=%h actual=%b/%h/%h required=1/%h/%h", op[16], op[15:8], op[7:0],
                   b_out_valid, b_out_z, b_out_tag, e[15:0], 4'(c - 3));
        end
      end
    end
    b_in_valid = 0;
  endtask

  task automatic test_w64;
    logic [63:0]  vx [250];
    logic [63:0]  vy [250];
    logic         vs [250];
    logic [63:0]  cor [5];
    logic [127:0] e;
    int k;
    cor[0] = 64'h0; cor[1] = 64'h1; cor[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    cor[3] = 64'h8000_0000_0000_0000; cor[4] = 64'h7FFF_FFFF_FFFF_FFFF;
    k = 0;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) begin
          vx[k] = cor[i]; vy[k] = cor[j]; vs[k] = (m == 1); k++;
        end
    for (int i = 50; i < 250; i++) begin
      vx[i] = {$urandom, $urandom}; vy[i] = {$urandom, $urandom}; vs[i] = i[0];
    end
    c_out_ready = 1;
    for (int c = 0; c < 253; c++) begin
      @(negedge clk);
      if (c < 250) begin
        c_in_valid = 1; c_in_signed = vs[c]; c_in_x = vx[c]; c_in_y = vy[c]; c_in_tag = 4'(c);
      end else c_in_valid = 0;
      #1;
      if (c >= 3) begin
        e = ref_mul(vx[c-3], vy[c-3], vs[c-3], 64);
        checks++;
        if (c_out_valid !== 1'b1 || c_out_z !== e || c_out_tag !== 4'(c - 3)) begin
          errors++;
          $display("FAIL w64 op=%0d actual=%b/%h/%h required=1/%h/%h", c - 3, c_out_valid, c_out_z, c_out_tag, e, 4'(c - 3));
        end
      end
    end
    c_in_valid = 0;
  endtask

  initial begin
    rst = 1;
    idle_all();
    test_reset();
    test_directed();
    test_stream();
    test_back_to_back();
    test_reset_mid();
    test_w8();
    test_w64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
